// File: rtl/train_sensor_sequencer.sv
// Tracks one train across N_SENSORS ordered track sensors, measures segment transit times,
// predicts the next one and flags overdue or out-of-order trains. Define TRAIN_BIDIR_EN for reverse runs and the dir output.
module train_sensor_sequencer #(
    parameter int N_SENSORS    = 6,
    parameter int TIME_W       = 19,
    parameter int DEFAULT_TIME = 5000,
    parameter int IDX_W        = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [N_SENSORS-1:0] sensor,
    input  logic                 clear,
    output logic [IDX_W-1:0]     seg_idx,
    output logic                 train_present,
    output logic [TIME_W-1:0]    transit_time,
    output logic                 transit_valid,
    output logic [TIME_W-1:0]    predicted_time,
    output logic                 alarm,
`ifdef TRAIN_BIDIR_EN
    output logic                 dir,
`endif
    output logic                 fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_ALARM = 2'd2
    } state_t;

    localparam logic [TIME_W-1:0]    DEF_T    = TIME_W'(DEFAULT_TIME);
    localparam logic [TIME_W-1:0]    T_MAX    = {TIME_W{1'b1}};
    localparam logic [TIME_W-1:0]    T_ZERO   = {TIME_W{1'b0}};
    localparam logic [TIME_W-1:0]    T_ONE    = {{(TIME_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]     IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_SENSORS - 1);
    localparam logic [N_SENSORS-1:0] S_ZERO   = {N_SENSORS{1'b0}};
    localparam logic [N_SENSORS-1:0] S_ONE    = {{(N_SENSORS-1){1'b0}}, 1'b1};

    state_t               state_r;
    logic [N_SENSORS-1:0] sync1_r, sync2_r, sync3_r, evt_r;
    logic [TIME_W-1:0]    timer_r, last_transit_r;

    logic [IDX_W-1:0]     exp_idx_s;
    logic [N_SENSORS-1:0] exp_mask_s;
    logic                 exp_hit_s, other_hit_s, timeout_s, last_seg_s, start_fwd_s;
    logic [TIME_W-1:0]    measured_s, pred_next_s;
    logic [TIME_W:0]      pred_sum_s;
`ifdef TRAIN_BIDIR_EN
    logic                 start_rev_s;
`endif

    // Two-flop synchronizer followed by a registered rising-edge detector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= S_ZERO;
            sync2_r <= S_ZERO;
            sync3_r <= S_ZERO;
            evt_r   <= S_ZERO;
        end else begin
            sync1_r <= sensor;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
            evt_r   <= sync2_r & ~sync3_r;
        end
    end

    // Expected-sensor decode, saturating measurement, prediction and timeout
    always_comb begin
`ifdef TRAIN_BIDIR_EN
        if (dir) begin
            exp_idx_s  = seg_idx - IDX_ONE;
            last_seg_s = (exp_idx_s == IDX_ZERO);
        end else begin
            exp_idx_s  = seg_idx + IDX_ONE;
            last_seg_s = (exp_idx_s == LAST_IDX);
        end
        start_fwd_s = evt_r[0] & ~evt_r[N_SENSORS-1];
        start_rev_s = evt_r[N_SENSORS-1] & ~evt_r[0];
`else
        exp_idx_s   = seg_idx + IDX_ONE;
        last_seg_s  = (exp_idx_s == LAST_IDX);
        start_fwd_s = evt_r[0];
`endif
        exp_mask_s  = S_ONE << exp_idx_s;
        exp_hit_s   = |(evt_r & exp_mask_s);
        other_hit_s = |(evt_r & ~exp_mask_s);
        if (tick && (timer_r != T_MAX)) begin
            measured_s = timer_r + T_ONE;
        end else begin
            measured_s = timer_r;
        end
        pred_sum_s  = {1'b0, last_transit_r} + {1'b0, measured_s};
        pred_next_s = TIME_W'(pred_sum_s >> 1);
        timeout_s   = {1'b0, timer_r} > {predicted_time, 1'b0};
    end

    // Sequencer FSM with registered outputs; fault hits outrank the expected hit, which outranks timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= S_IDLE;
            seg_idx        <= IDX_ZERO;
            train_present  <= 1'b0;
            transit_time   <= T_ZERO;
            transit_valid  <= 1'b0;
            predicted_time <= DEF_T;
            alarm          <= 1'b0;
            fault          <= 1'b0;
            timer_r        <= T_ZERO;
            last_transit_r <= DEF_T;
`ifdef TRAIN_BIDIR_EN
            dir            <= 1'b0;
`endif
        end else begin
            transit_valid <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start_fwd_s) begin
                        state_r        <= S_TRACK;
                        seg_idx        <= IDX_ZERO;
                        timer_r        <= T_ZERO;
                        predicted_time <= DEF_T;
                        train_present  <= 1'b1;
`ifdef TRAIN_BIDIR_EN
                        dir            <= 1'b0;
                    end else if (start_rev_s) begin
                        state_r        <= S_TRACK;
                        seg_idx        <= LAST_IDX;
                        timer_r        <= T_ZERO;
                        predicted_time <= DEF_T;
                        train_present  <= 1'b1;
                        dir            <= 1'b1;
`endif
                    end
                end
                S_TRACK: begin
                    if (other_hit_s) begin
                        state_r       <= S_ALARM;
                        alarm         <= 1'b1;
                        fault         <= 1'b1;
                        train_present <= 1'b0;
                    end else if (exp_hit_s) begin
                        transit_time   <= measured_s;
                        transit_valid  <= 1'b1;
                        last_transit_r <= measured_s;
                        seg_idx        <= exp_idx_s;
                        timer_r        <= T_ZERO;
                        if (last_seg_s) begin
                            state_r       <= S_IDLE;
                            train_present <= 1'b0;
                        end else begin
                            predicted_time <= pred_next_s;
                        end
                    end else if (timeout_s) begin
                        state_r       <= S_ALARM;
                        alarm         <= 1'b1;
                        train_present <= 1'b0;
                    end else begin
                        timer_r <= measured_s;
                    end
                end
                S_ALARM: begin
                    if (clear) begin
                        state_r <= S_IDLE;
                        alarm   <= 1'b0;
                        fault   <= 1'b0;
                        seg_idx <= IDX_ZERO;
                    end
                end
                default: begin
                    state_r       <= S_IDLE;
                    alarm         <= 1'b0;
                    fault         <= 1'b0;
                    train_present <= 1'b0;
                end
            endcase
        end
    end

endmodule
